// File: rtl/dot_matrix_scanner_if.sv
// Game-controller / display-pin bundle for the dot-matrix scanner.
// master: drives board and cursor state, observes pins; slave: the scanner.
interface dot_matrix_scanner_if #(
   parameter int ROWS   = 10,
   parameter int COLS   = 14,
   parameter int N      = 3,
   parameter int CIDX_W = 4
);
   logic [2*N*N-1:0]  board;
   logic [3:0]        v_offset;
   logic              cursor_en;
   logic [CIDX_W-1:0] cursor_idx;
   logic [ROWS-1:0]   dot_row;
   logic [COLS-1:0]   dot_col;
   logic              frame_done;

   modport master (
      output board, v_offset, cursor_en, cursor_idx,
      input  dot_row, dot_col, frame_done
   );

   modport slave (
      input  board, v_offset, cursor_en, cursor_idx,
      output dot_row, dot_col, frame_done
   );
endinterface

// File: rtl/dot_matrix_scanner.sv
// Row-scan driver: renders an N x N board of 2-bit cells as 3x3 glyphs on a 4-pixel pitch.
// One row per divider tick, all outputs registered; free-running, accepts no backpressure.
module dot_matrix_scanner #(
   parameter int CLK_DIV      = 12499,
   parameter int ROWS         = 10,
   parameter int COLS         = 14,
   parameter int N            = 3,
   parameter int CIDX_W       = 4,
   parameter int BLINK_FRAMES = 32
) (
   input logic                 freq,
   input logic                 rst,
   dot_matrix_scanner_if.slave bus
);
   localparam int DIV_W = (CLK_DIV > 0) ? $clog2(CLK_DIV + 1) : 1;
   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam int LW    = (ROW_W >= 4) ? ROW_W + 1 : 5;
   localparam int CR_W  = LW - 2;

   typedef struct packed {
      logic [2*N*N-1:0]  board;
      logic [3:0]        v_offset;
      logic              cursor_en;
      logic [CIDX_W-1:0] cursor_idx;
   } shadow_t;

   logic [DIV_W-1:0] div_cnt;
   logic [ROW_W-1:0] row_idx;
   logic [ROWS-1:0]  dot_row_q;
   logic [COLS-1:0]  dot_col_q;
   logic             frame_done_q;
   shadow_t          shadow;
   logic [BLK_W-1:0] blk_cnt;
   logic             phase;

   logic             tick;
   logic             wrap;
   logic             blk_wrap;
   logic             phase_nxt;
   logic [ROW_W-1:0] row_next;
   shadow_t          live;
   shadow_t          ren;
   logic [LW-1:0]    lrow;
   logic [CR_W-1:0]  cr;
   logic [1:0]       sr;
   logic             cur_on;
   logic [N-1:0][1:0] codes;
   logic [N-1:0]     hit;
   logic [COLS-1:0]  pat;

   // Both glyphs are checkerboards over the 3x3 cell: code 1 lights pixels where
   // exactly one of (sub-row, sub-col) is the middle, code 2 is its complement.
   function automatic logic glyph_px(input logic [1:0] code, input logic [1:0] sub_row, input int sub_col);
      logic mid;
      mid = (sub_row == 2'd1) ^ (sub_col == 1);
      case (code)
         2'd1:    return mid;
         2'd2:    return ~mid;
         default: return 1'b0;
      endcase
   endfunction

   assign tick      = (div_cnt == DIV_W'(CLK_DIV));
   assign row_next  = (row_idx == ROW_W'(ROWS - 1)) ? '0 : row_idx + ROW_W'(1);
   assign wrap      = tick && (row_idx == ROW_W'(ROWS - 1));
   assign blk_wrap  = wrap && (blk_cnt == BLK_W'(BLINK_FRAMES - 1));
   assign phase_nxt = blk_wrap ? ~phase : phase;

   // At a frame boundary row 0 must already reflect the freshly sampled inputs.
   assign live   = {bus.board, bus.v_offset, bus.cursor_en, bus.cursor_idx};
   assign ren    = wrap ? live : shadow;
   assign cur_on = ren.cursor_en && phase_nxt;

   assign lrow = LW'(row_next) + LW'(ren.v_offset);
   assign cr   = lrow[LW-1:2];
   assign sr   = lrow[1:0];

   always_comb begin
      codes = '0;
      hit   = '0;
      pat   = '0;
      for (int c = 0; c < N; c++) begin
         for (int r = 0; r < N; r++) begin
            if (cr == CR_W'(r)) begin
               codes[c] = ren.board[2*(r*N+c) +: 2];
               hit[c]   = cur_on && (ren.cursor_idx == CIDX_W'(r*N + c));
            end
         end
      end
      // Rows below the board leave codes/hit at zero; gap pixels are never written.
      if (sr != 2'd3) begin
         for (int c = 0; c < N; c++) begin
            for (int s = 0; s < 3; s++) begin
               pat[COLS-1-(4*c+s)] = glyph_px(codes[c], sr, s) ^ hit[c];
            end
         end
      end
   end

   always_ff @(posedge freq or posedge rst) begin
      if (rst) begin
         div_cnt      <= '0;
         row_idx      <= '0;
         dot_row_q    <= ROWS'(1);
         dot_col_q    <= '0;
         frame_done_q <= 1'b0;
         shadow       <= '0;
         blk_cnt      <= '0;
         phase        <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         div_cnt      <= tick ? '0 : div_cnt + DIV_W'(1);
         if (tick) begin
            row_idx   <= row_next;
            dot_row_q <= ROWS'(1) << row_next;
            dot_col_q <= pat;
         end
         if (wrap) begin
            shadow       <= live;
            frame_done_q <= 1'b1;
            blk_cnt      <= blk_wrap ? '0 : blk_cnt + BLK_W'(1);
            phase        <= phase_nxt;
         end
      end
   end

   assign bus.dot_row    = dot_row_q;
   assign bus.dot_col    = dot_col_q;
   assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_dot_matrix_scanner.sv
// Scoreboard bench for dot_matrix_scanner: stimulus queues expected rows, a monitor checks each row update.
module tb_dot_matrix_scanner;
   localparam int CLK_DIV = 3;
   localparam int ROWS    = 10;
   localparam int COLS    = 14;
   localparam int N       = 3;
   localparam int CIDX_W  = 4;
   localparam int BLINK   = 2;
   localparam int LIMIT   = 2000;

   typedef struct {
      int              test;
      int              r;
      logic [COLS-1:0] col;
   } exp_t;

   logic freq;
   logic rst;
   int   n_tests;
   int   n_fail;
   exp_t exp_q[$];
   logic [COLS-1:0] fr [ROWS];

   localparam logic [COLS-1:0] C_101_L  = 14'b10100000000000;
   localparam logic [COLS-1:0] C_010_L  = 14'b01000000000000;
   localparam logic [COLS-1:0] C_111_L  = 14'b11100000000000;
   localparam logic [COLS-1:0] C_010_R  = 14'b00000000010000;
   localparam logic [COLS-1:0] C_101_R  = 14'b00000000101000;
   localparam logic [COLS-1:0] C_101_M  = 14'b00001010000000;
   localparam logic [COLS-1:0] C_010_M  = 14'b00000100000000;

   dot_matrix_scanner_if #(.ROWS(ROWS), .COLS(COLS), .N(N), .CIDX_W(CIDX_W)) bus ();

   dot_matrix_scanner #(
      .CLK_DIV(CLK_DIV), .ROWS(ROWS), .COLS(COLS), .N(N),
      .CIDX_W(CIDX_W), .BLINK_FRAMES(BLINK)
   ) dut (
      .freq(freq),
      .rst (rst),
      .bus (bus)
   );

   initial freq = 1'b0;
   always #5 freq = ~freq;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, expv);
      end
   endtask

   task automatic timeout(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: timed out after %0d cycles, expected the event", name, LIMIT);
   endtask

   task automatic clear_fr();
      for (int r = 0; r < ROWS; r++) fr[r] = '0;
   endtask

   task automatic push_frame(input int test);
      for (int r = 0; r < ROWS; r++) exp_q.push_back('{test: test, r: r, col: fr[r]});
   endtask

   task automatic wait_row(input int r, input string name);
      bit found;
      found = 0;
      for (int n = 0; n < LIMIT && !found; n++) begin
         @(negedge freq);
         #1;
         if (bus.dot_row == (ROWS'(1) << r)) found = 1;
      end
      if (!found) timeout(name);
   endtask

   task automatic drain(input string name);
      bit done;
      done = 0;
      for (int n = 0; n < LIMIT && !done; n++) begin
         @(negedge freq);
         #1;
         if (exp_q.size() == 0) done = 1;
      end
      if (!done) begin
         timeout(name);
         exp_q.delete();
      end
   endtask

   // Monitor: every change of dot_row is one presented row; compare against the queue head.
   initial begin
      logic [ROWS-1:0] prev_row;
      int   gap;
      bit   chk_fd;
      exp_t e;
      prev_row = '0;
      gap      = 0;
      chk_fd   = 0;
      forever begin
         @(negedge freq);
         if (chk_fd) begin
            chk_fd = 0;
            check("frame_done_width", 32'(bus.frame_done), 32'd0);
         end
         if (rst) begin
            gap      = 0;
            prev_row = bus.dot_row;
         end else begin
            gap++;
            if (bus.dot_row != prev_row) begin
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check($sformatf("t%0d_row%0d_onehot", e.test, e.r), 32'(bus.dot_row), 32'(ROWS'(1) << e.r));
                  check($sformatf("t%0d_row%0d_col", e.test, e.r), 32'(bus.dot_col), 32'(e.col));
                  check($sformatf("t%0d_row%0d_fdone", e.test, e.r), 32'(bus.frame_done), 32'(e.r == 0));
                  check($sformatf("t%0d_row%0d_period", e.test, e.r), 32'(gap), 32'(CLK_DIV + 1));
                  if (e.r == 0) chk_fd = 1;
               end
               gap      = 0;
               prev_row = bus.dot_row;
            end
         end
      end
   end

   initial begin
      n_tests        = 0;
      n_fail         = 0;
      rst            = 1'b1;
      bus.board      = '0;
      bus.v_offset   = '0;
      bus.cursor_en  = 1'b0;
      bus.cursor_idx = '0;
      repeat (3) @(negedge freq);
      #1;
      check("reset_dot_row", 32'(bus.dot_row), 32'd1);
      check("reset_dot_col", 32'(bus.dot_col), 32'd0);
      check("reset_frame_done", 32'(bus.frame_done), 32'd0);
      @(negedge freq);
      #1 rst = 1'b0;

      // 1: blank board, two full frames
      wait_row(9, "t1_sync");
      clear_fr();
      push_frame(1);
      push_frame(1);
      drain("t1_drain");

      // 2: cell 0 = code 2
      bus.board = 18'h00002;
      clear_fr();
      fr[0] = C_101_L;
      fr[1] = C_010_L;
      fr[2] = C_101_L;
      push_frame(2);
      drain("t2_drain");

      // 3: cell 8 = code 1, then scrolled by one row
      bus.board = 18'h10000;
      clear_fr();
      fr[8] = C_010_R;
      fr[9] = C_101_R;
      push_frame(3);
      drain("t3a_drain");
      bus.v_offset = 4'd1;
      clear_fr();
      fr[7] = C_010_R;
      fr[8] = C_101_R;
      fr[9] = C_010_R;
      push_frame(3);
      drain("t3b_drain");

      // 4: board changes mid-frame, visible only from the next frame
      bus.board    = '0;
      bus.v_offset = 4'd0;
      clear_fr();
      push_frame(4);
      wait_row(5, "t4_row5");
      bus.board = 18'h00200;
      fr[4] = C_101_M;
      fr[5] = C_010_M;
      fr[6] = C_101_M;
      push_frame(4);
      drain("t4_drain");

      // 6: asynchronous reset in the middle of row 4
      wait_row(4, "t6_row4");
      @(negedge freq);
      #1;
      check("t6_pre_col", 32'(bus.dot_col), 32'(C_101_M));
      rst = 1'b1;
      #1;
      check("t6_rst_dot_row", 32'(bus.dot_row), 32'd1);
      check("t6_rst_dot_col", 32'(bus.dot_col), 32'd0);
      check("t6_rst_frame_done", 32'(bus.frame_done), 32'd0);
      bus.board      = '0;
      bus.cursor_en  = 1'b1;
      bus.cursor_idx = 4'd0;
      repeat (2) @(negedge freq);
      #1 rst = 1'b0;
      repeat (CLK_DIV) @(posedge freq);
      #1;
      check("t6_hold_row0", 32'(bus.dot_row), 32'd1);
      @(posedge freq);
      #1;
      check("t6_restart_row1", 32'(bus.dot_row), 32'd2);

      // 5: cursor blink on cell 0; frames 1..6 after reset have phase 0,1,1,0,0,1
      wait_row(9, "t5_sync");
      for (int f = 1; f <= 6; f++) begin
         clear_fr();
         if (f == 2 || f == 3 || f == 6) begin
            fr[0] = C_111_L;
            fr[1] = C_111_L;
            fr[2] = C_111_L;
         end
         push_frame(5);
      end
      drain("t5a_drain");
      bus.cursor_idx = 4'd9;
      clear_fr();
      push_frame(5);
      push_frame(5);
      drain("t5b_drain");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/dot_matrix_scanner.md
Name: dot_matrix_scanner

Overview:
- Parametrised row-scan driver for the dot-matrix display. It renders an N×N game board of 2-bit cells as 3×3 glyphs on a 4-pixel pitch.
- Adds four features:
  - frame-synchronous board latching, so a frame never shows two different boards;
  - a vertical scroll offset (generalises the old one-bit shift);
  - a blinking cursor cell;
  - a frame-done pulse.
- Sits between the game controller (board, cursor) and the display pins (dot_row, dot_col).

Parameters:
- CLK_DIV, 12499, tick period is CLK_DIV+1 freq cycles (25 MHz → 2 kHz row rate).
- ROWS, 10, physical display rows.
- COLS, 14, physical display columns.
- N, 3, board dimension (N×N cells); 4N-1 ≤ COLS required.
- CIDX_W, 4, cursor index width; 2^CIDX_W ≥ N*N.
- BLINK_FRAMES, 32, frames per cursor blink half-period.

Ports:
- freq  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous reset, active-high.
- board  in  2*N*N  cell i = board[2i+1:2i]; i = r*N + c, r = cell row (0 = top), c = cell column (0 = left).
- v_offset  in  4  logical rows scrolled up; sampled at frame boundary.
- cursor_en  in  1  enable cursor blink; sampled at frame boundary.
- cursor_idx  in  CIDX_W  cursor cell index; sampled at frame boundary.
- dot_row  out  ROWS  one-hot active row; bit 0 = top.
- dot_col  out  COLS  column data for the active row; bit COLS-1 = leftmost column.
- frame_done  out  1  one-cycle pulse when the scan wraps to row 0.

Behaviour:
- Reset (async, any time): divider=0, row_idx=0, dot_row=1, dot_col=0, frame_done=0, shadow board/offset/cursor=0, blink counter=0, phase=0.
- Divider:
  - Counts 0..CLK_DIV, then back to 0.
  - tick is asserted in the freq cycle where count==CLK_DIV.
  - With CLK_DIV=0, tick fires every cycle.
- Row advance on tick:
  - next = (row_idx==ROWS-1) ? 0 : row_idx+1.
  - Registered in the same edge: row_idx←next, dot_row←1<<next, dot_col←pattern(next).
  - dot_row and dot_col therefore always change together.
- Frame boundary (tick with next==0):
  - shadow←{board, v_offset, cursor_en, cursor_idx}.
  - frame_done=1 for that one cycle only.
  - pattern(0) uses the newly sampled values in the same edge.
  - Input changes mid-frame have no visible effect until the next boundary.
- Blink:
  - Frame counter counts 0..BLINK_FRAMES-1 at frame boundaries.
  - On wrap, phase toggles.
- Rendering for physical row p:
  - Logical row L = p + shadow_offset (5-bit, no wrap); cell row cr = L/4, sub-row sr = L%4.
  - sr==3 or cr ≥ N → dot_col = 0.
  - Logical column x = COLS-1-bit; cell column cc = x/4, sub-column sc = x%4.
  - sc==3 or cc ≥ N → bit = 0.
- Glyphs (3×3, top/mid/bottom row, left→right):
  - code 0: 000/000/000.
  - code 1: 010/101/010.
  - code 2: 101/010/101.
  - code 3: treated as 0.
- Cursor:
  - Applies when shadow cursor_en=1, phase=1 and cursor_idx < N*N.
  - That cell's glyph is XORed with 111/111/111.
  - Gap pixels are never affected.
  - cursor_idx ≥ N*N: no cursor is drawn.
- Combinational glyph lookup is allowed.
- Outputs are registered only; no glitching on dot_row/dot_col.

Test Plan:
1. Reset then release, CLK_DIV=3, board=0 → dot_row 1→2→4… changes every 4 freq cycles; after row 9 it returns to 1 with frame_done=1 for exactly one cycle; dot_col=0 throughout.
2. board cell0=2, other cells 0, offset 0, frame wraps to row 0 → row0 dot_col=14'b10100000000000, row1=14'b01000000000000, row2=14'b10100000000000, row3=0.
3. Cell 8=1, offset 0 → rows 8 and 9 show cols 9..11 as 010 then 101: row8=14'b00000000010000, row9=14'b00000000101000; set v_offset=1 → after the next boundary row8=14'b00000000101000, row9=14'b00000000010000 (the cell's bottom row lands on row 9).
4. Change board from 0 to cell4=2 while row 5 is active → rows 5–9 stay 0 for the rest of that frame; the glyph appears in rows 4–6 of the next frame.
5. BLINK_FRAMES=2, cursor_en=1, cursor_idx=0, board=0 → row0 alternates 0 and 14'b11100000000000 every 2 frames; cursor_idx=9 → always 0.
6. Assert rst mid-row with dot_row=16 → immediate dot_row=1, dot_col=0, frame_done=0; after release, the scan restarts from divider 0.
